// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared period counter with edge/center-aligned
// modes, per-channel polarity, and shadowed configuration that updates only at period boundaries.
module pwm_multi_channel #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          period,
  input  logic [WIDTH*CHANNELS-1:0] active,
  input  logic [CHANNELS-1:0]       polarity,
  input  logic                      center,
  input  logic                      start,
  input  logic                      stop,
  output logic [CHANNELS-1:0]       pwmOut,
  output logic                      running,
  output logic                      period_done
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic {UP, DOWN}  dir_t;

  state_t                    state, next_state;
  dir_t                      dir, dir_next;
  logic [WIDTH-1:0]          cnt, cnt_next;
  logic [WIDTH-1:0]          sh_period;
  logic [WIDTH*CHANNELS-1:0] sh_active;
  logic [CHANNELS-1:0]       sh_pol;
  logic                      sh_center;

  logic                      accept, boundary, load, done_next;
  logic [WIDTH-1:0]          p_next;
  logic [WIDTH*CHANNELS-1:0] a_next;
  logic [CHANNELS-1:0]       pol_next, pwm_next;
  logic                      c_next;

  // Saturation at A>=P keeps P-A from underflowing in the center-mode compare.
  function automatic logic raw_level(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] p,
                                     input logic [WIDTH-1:0] a, input logic ctr);
    if (a >= p)   return 1'b1;
    else if (ctr) return c >= (p - a);
    else          return c < a;
  endfunction

  assign accept   = (state == IDLE) && start && !stop;
  assign boundary = (state == RUN) && !stop &&
                    (sh_center ? (dir == DOWN && cnt == '0) : (cnt == sh_period - WIDTH'(1)));
  assign load     = accept || boundary;

  assign p_next   = load ? period   : sh_period;
  assign a_next   = load ? active   : sh_active;
  assign pol_next = load ? polarity : sh_pol;
  assign c_next   = load ? center   : sh_center;

  assign running  = (state == RUN);

  // NOTE: asynchronous reset lives only in the sensitivity list; nothing else may be edge-triggered on it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept && period != '0) next_state = RUN;
      RUN: begin
        if (stop)                            next_state = IDLE;
        else if (boundary && period == '0)   next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cnt_next  = '0;
    dir_next  = UP;
    done_next = 1'b0;
    if (state == RUN && !stop) begin
      if (boundary) begin
        done_next = 1'b1;
      end else if (sh_center) begin
        if (dir == UP) begin
          // Peak value is held for a second cycle as the first down-phase step.
          if (cnt == sh_period - WIDTH'(1)) begin
            cnt_next = cnt;
            dir_next = DOWN;
          end else begin
            cnt_next = cnt + WIDTH'(1);
          end
        end else begin
          cnt_next = cnt - WIDTH'(1);
          dir_next = DOWN;
        end
      end else begin
        cnt_next = cnt + WIDTH'(1);
      end
    end
    if (next_state == IDLE) begin
      cnt_next = '0;
      dir_next = UP;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (next_state == RUN)
        pwm_next[i] = raw_level(cnt_next, p_next, a_next[i*WIDTH +: WIDTH], c_next) ^ pol_next[i];
      else
        pwm_next[i] = pol_next[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      dir         <= UP;
      sh_period   <= '0;
      sh_active   <= '0;
      sh_pol      <= '0;
      sh_center   <= 1'b0;
      pwmOut      <= '0;
      period_done <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      dir         <= dir_next;
      sh_period   <= p_next;
      sh_active   <= a_next;
      sh_pol      <= pol_next;
      sh_center   <= c_next;
      pwmOut      <= pwm_next;
      period_done <= done_next;
    end
  end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
- Parametrised successor to the single-channel TOPPWM generator: CHANNELS independent duty outputs share one period counter.
- Adds configurable counter width, a center-aligned mode, per-channel polarity and shadow registers for glitch-free reconfiguration.
- Sits between the control/register logic, which drives period, duty, start and stop, and the output pins.

Parameters:
- WIDTH, 16, width of period, duty and counter.
- CHANNELS, 4, number of PWM outputs.

Ports:
- clk  input  1  system clock; all flops are clocked on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- period  input  WIDTH  cycles per edge-aligned period; half-period in center mode.
- active  input  WIDTH*CHANNELS  duty per channel; channel i is bits [i*WIDTH +: WIDTH].
- polarity  input  CHANNELS  1 = output inverted; also sets the idle level.
- center  input  1  0 = edge-aligned, 1 = center-aligned.
- start  input  1  level or pulse; starts generation when idle.
- stop  input  1  halts generation.
- pwmOut  output  CHANNELS  PWM outputs, registered.
- running  output  1  high while generating.
- period_done  output  1  one-cycle pulse at each period boundary.

Behaviour:
- Reset (reset=0, asynchronous):
  - cnt=0, dir=up, running=0, period_done=0.
  - All shadow registers cleared.
  - pwmOut=0.
- Shadow registers hold period, active, polarity and center.
  - They load on the edge where start is accepted and at every period boundary while running.
  - Input changes mid-period have no effect until the next boundary.
- States: IDLE and RUN.
- IDLE:
  - pwmOut = shadow polarity (inactive level); cnt held at 0.
  - start=1 and stop=0 at an edge: load shadows, cnt<=0, dir<=up, running<=1, enter RUN.
- RUN, edge-aligned mode:
  - cnt counts 0..P-1, then wraps to 0.
  - period_done pulses on the cycle cnt returns to 0.
  - Raw output = (cnt < A).
- RUN, center-aligned mode:
  - Count sequence is 0,1..P-1 (up), then P-1..1,0 (down).
  - Each end value is held for one cycle, giving a full cycle of 2P clocks.
  - Raw output = (cnt >= P-A), so there are 2A high cycles centred on the peak.
  - Boundary is after the down-phase 0; period_done pulses there.
- pwmOut[i] is registered from the current shadow values: raw_i XOR polarity_i.
  - First output cycle after start reflects cnt=0.
- Latency: the edge that accepts start also loads pwmOut for cnt=0, so output is valid one cycle after start is sampled high.
- stop=1 at any edge in RUN:
  - Next state IDLE; running<=0; pwmOut<=polarity.
  - Shadows are kept; no period_done.
- Simultaneous events:
  - start and stop together: stop wins.
  - start while already running is ignored.
- Boundary conditions:
  - P=0: when the shadow loads P=0, the block goes to IDLE at that edge and outputs take the idle level. This applies at start (start is not accepted) and at a boundary (running drops).
  - A=0: constant inactive level.
  - A>=P: constant active level; duty saturates and there is no wrap artefact.
  - Edge mode with P=1: output active iff A>=1; period_done every cycle.
  - Width: compare at WIDTH bits; P-A is computed only when A<P, so there is no underflow.
- Reset mid-operation: immediate return to the reset values; on release the block stays in IDLE until the next start.

Test Plan:
- Edge mode, P=20, A=10 on ch0, polarity=0; start pulse for 1 cycle -> ch0 repeats 10 high, 10 low; period_done every 20 cycles; running=1.
- A=15 written at cnt=5 of a running period -> the current period keeps 10 high; the next period has 15 high, 5 low.
- Center mode, P=8, A=3 -> period 16 cycles; high for cnt>=5, i.e. 6 consecutive high cycles spanning the up/down peak.
- Channels configured A=0, A=20, A=25, polarity[3]=1 with A=5 at P=20 -> ch0 constant 0; ch1 and ch2 constant 1; ch3 low 5 cycles, high 15 cycles.
- stop asserted mid-period with polarity=4'b0101 -> pwmOut=4'b0101 and running=0 after one edge; start and stop together from IDLE -> stays IDLE.
- Async reset low mid-RUN -> outputs 0 immediately without a clock edge; start with P=0 -> running remains 0.
